// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular two-input round-robin arbiter for AXI4-Stream.
// Holds a grant from the first beat to the accepted tlast beat, then passes through IDLE.
module axis_pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int MTY_WIDTH  = 6
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  arb_enable,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [MTY_WIDTH-1:0]  s0_axis_tuser_mty,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [MTY_WIDTH-1:0]  s1_axis_tuser_mty,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
    output logic                  m_axis_tuser_src,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           pkt_cnt_0,
    output logic [31:0]           pkt_cnt_1,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Handshake rule on every port: a beat moves on a clock edge where tvalid and
    // tready are both high; the granted source sees m_axis_tready unchanged.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   pkt_done;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // A tlast acceptance always lands in IDLE; the next grant costs one more cycle.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (arb_enable) begin
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        if (last_grant) begin
                            state_nxt      = GRANT0;
                            last_grant_nxt = 1'b0;
                        end else begin
                            state_nxt      = GRANT1;
                            last_grant_nxt = 1'b1;
                        end
                    end else if (s0_axis_tvalid) begin
                        state_nxt      = GRANT0;
                        last_grant_nxt = 1'b0;
                    end else if (s1_axis_tvalid) begin
                        state_nxt      = GRANT1;
                        last_grant_nxt = 1'b1;
                    end
                end
            end
            GRANT0, GRANT1: begin
                if (pkt_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata     = '0;
        m_axis_tuser_mty = '0;
        m_axis_tuser_src = 1'b0;
        m_axis_tvalid    = 1'b0;
        m_axis_tlast     = 1'b0;
        s0_axis_tready   = 1'b0;
        s1_axis_tready   = 1'b0;
        case (state)
            GRANT0: begin
                m_axis_tdata     = s0_axis_tdata;
                m_axis_tuser_mty = s0_axis_tuser_mty;
                m_axis_tvalid    = s0_axis_tvalid;
                m_axis_tlast     = s0_axis_tlast;
                s0_axis_tready   = m_axis_tready;
            end
            GRANT1: begin
                m_axis_tdata     = s1_axis_tdata;
                m_axis_tuser_mty = s1_axis_tuser_mty;
                m_axis_tuser_src = 1'b1;
                m_axis_tvalid    = s1_axis_tvalid;
                m_axis_tlast     = s1_axis_tlast;
                s1_axis_tready   = m_axis_tready;
            end
            default: ;
        endcase
    end

    assign pkt_done  = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else if (pkt_done) begin
            if (state == GRANT0) pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
            if (state == GRANT1) pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: per-source expected-beat queues drained by a
// negedge monitor, plus a packet-level arbitration model.
module tb_axis_pkt_rr_arbiter;
    localparam int DW = 512;
    localparam int MW = 6;
    localparam int W  = DW + MW + 1;

    logic          axis_aclk = 1'b0;
    logic          axis_aresetn;
    logic          arb_enable;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata;
    logic [MW-1:0] s0_axis_tuser_mty, s1_axis_tuser_mty;
    logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [MW-1:0] m_axis_tuser_mty;
    logic          m_axis_tuser_src, m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]   pkt_cnt_0, pkt_cnt_1;
    logic          busy;
    logic [1:0]    state_dbg;

    axis_pkt_rr_arbiter #(.DATA_WIDTH(DW), .MTY_WIDTH(MW)) dut (
        .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn), .arb_enable(arb_enable),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tuser_mty(s0_axis_tuser_mty),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tuser_mty(s1_axis_tuser_mty),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser_mty(m_axis_tuser_mty),
        .m_axis_tuser_src(m_axis_tuser_src), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 axis_aclk = ~axis_aclk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           done_q[$];

    // Packet-level reference: who owns the output, who was served last, counts.
    logic         mdl_busy = 1'b0;
    logic         mdl_src  = 1'b0;
    logic         mdl_last = 1'b1;
    logic [31:0]  mdl_cnt0 = '0;
    logic [31:0]  mdl_cnt1 = '0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_word;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge axis_aclk) begin
        logic [W-1:0] exp_w;
        logic         src_v;
        if (!axis_aresetn) begin
            check("rst_busy", busy, 0);
            check("rst_mvalid", m_axis_tvalid, 0);
            check("rst_cnt", {pkt_cnt_1, pkt_cnt_0}, 0);
            mdl_busy = 1'b0; mdl_last = 1'b1; mdl_cnt0 = '0; mdl_cnt1 = '0;
            stall_prev = 1'b0;
            exp_q0.delete(); exp_q1.delete(); done_q.delete();
        end else begin
            check("cnt0", pkt_cnt_0, mdl_cnt0);
            check("cnt1", pkt_cnt_1, mdl_cnt1);
            check("busy", busy, mdl_busy);
            if (mdl_busy) begin
                src_v = mdl_src ? s1_axis_tvalid : s0_axis_tvalid;
                check("src", m_axis_tuser_src, mdl_src);
                check("pass_valid", m_axis_tvalid, src_v);
                check("gr_ready", mdl_src ? s1_axis_tready : s0_axis_tready, m_axis_tready);
                check("other_ready", mdl_src ? s0_axis_tready : s1_axis_tready, 0);
                if (stall_prev)
                    check("stable", {m_axis_tdata, m_axis_tuser_mty, m_axis_tlast}, stall_word);
                if (m_axis_tvalid && m_axis_tready) begin
                    if ((mdl_src ? exp_q1.size() : exp_q0.size()) == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        exp_w = mdl_src ? exp_q1.pop_front() : exp_q0.pop_front();
                        check("beat", {m_axis_tdata, m_axis_tuser_mty, m_axis_tlast}, exp_w);
                    end
                    if (m_axis_tlast) begin
                        mdl_busy = 1'b0;
                        if (mdl_src) mdl_cnt1 = mdl_cnt1 + 1; else mdl_cnt0 = mdl_cnt0 + 1;
                        done_q.push_back(int'(mdl_src));
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = m_axis_tvalid;
                    stall_word = {m_axis_tdata, m_axis_tuser_mty, m_axis_tlast};
                end
            end else begin
                check("idle_data", {m_axis_tdata, m_axis_tuser_mty, m_axis_tlast}, 0);
                check("idle_hs", {m_axis_tvalid, s0_axis_tready, s1_axis_tready}, 0);
                stall_prev = 1'b0;
                if (arb_enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    if (s0_axis_tvalid && s1_axis_tvalid) mdl_src = ~mdl_last;
                    else                                  mdl_src = s1_axis_tvalid;
                    mdl_last = mdl_src;
                    mdl_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_src(input int src, input logic v, input logic [DW-1:0] d,
                             input logic [MW-1:0] mty, input logic last);
        if (src == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tuser_mty = mty; s0_axis_tlast = last;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tuser_mty = mty; s1_axis_tlast = last;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
    task automatic send_pkt(input int src, input int len, input int gap_max);
        logic [DW-1:0] d;
        logic [MW-1:0] mty;
        logic          last, acc;
        int            gap, budget;
        for (int b = 0; b < len; b++) begin
            gap = $urandom_range(gap_max, 0);
            if (gap > 0) begin
                drive_src(src, 1'b0, '0, '0, 1'b0);
                repeat (gap) @(posedge axis_aclk);
                #1;
            end
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
            last = (b == len - 1);
            mty  = last ? MW'($urandom_range(63, 0)) : '0;
            if (src == 0) exp_q0.push_back({d, mty, last});
            else          exp_q1.push_back({d, mty, last});
            drive_src(src, 1'b1, d, mty, last);
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 2000) begin
                @(negedge axis_aclk);
                acc = (src == 0) ? s0_axis_tready : s1_axis_tready;
                @(posedge axis_aclk);
                budget++;
            end
            #1;
            if (!acc) begin
                fail_now("driver_wait");
                b = len;
            end
        end
        drive_src(src, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge axis_aclk); #1;
        axis_aresetn = 1'b0;
        repeat (2) @(posedge axis_aclk);
        #1 axis_aresetn = 1'b1;
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && budget < 500) begin
            @(posedge axis_aclk);
            budget++;
        end
        if (budget >= 500) fail_now("drain");
        @(posedge axis_aclk); #1;
    endtask

    task automatic wait_busy();
        int budget = 0;
        while (!busy && budget < 200) begin
            @(negedge axis_aclk);
            budget++;
        end
        if (budget >= 200) fail_now("wait_busy");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c0;
        logic        drv_done;
        axis_aresetn  = 1'b0;
        arb_enable    = 1'b1;
        m_axis_tready = 1'b1;
        drive_src(0, 1'b0, '0, '0, 1'b0);
        drive_src(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge axis_aclk);
        #1 axis_aresetn = 1'b1;

        // single-beat packet on s0
        send_pkt(0, 1, 0);
        drain();
        check("single_cnt0", pkt_cnt_0, 1);
        check("single_cnt1", pkt_cnt_1, 0);

        // both sources with 3-beat packets right after reset
        do_reset();
        fork
            send_pkt(0, 3, 0);
            send_pkt(1, 3, 0);
        join
        drain();
        check("both_order_len", done_q.size(), 2);
        if (done_q.size() == 2) begin
            check("both_first", done_q[0], 0);
            check("both_second", done_q[1], 1);
        end
        check("both_cnt", {pkt_cnt_1, pkt_cnt_0}, {32'd1, 32'd1});

        // s0 streams 4 packets back-to-back while s1 has one pending
        do_reset();
        fork
            begin repeat (4) send_pkt(0, 2, 0); end
            send_pkt(1, 2, 0);
        join
        drain();
        check("starve_len", done_q.size(), 5);
        if (done_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check("starve_order", done_q[i], (i == 1) ? 1 : 0);
        end

        // downstream backpressure for 5 cycles mid-packet
        fork
            send_pkt(0, 3, 0);
            begin
                wait_busy();
                @(posedge axis_aclk); #1;
                c0 = pkt_cnt_0;
                m_axis_tready = 1'b0;
                repeat (5) begin
                    @(negedge axis_aclk);
                    check("hold_sready", s0_axis_tready, 0);
                    check("hold_cnt", pkt_cnt_0, c0);
                end
                @(posedge axis_aclk); #1;
                m_axis_tready = 1'b1;
            end
        join
        drain();

        // arb_enable drops during the second beat; s1 waits until it rises again
        fork
            send_pkt(0, 3, 0);
            begin repeat (2) @(posedge axis_aclk); #1; send_pkt(1, 1, 0); end
            begin
                wait_busy();
                @(posedge axis_aclk); #1;
                arb_enable = 1'b0;
                repeat (6) @(negedge axis_aclk);
                check("dis_busy", busy, 0);
                check("dis_s1_ready", s1_axis_tready, 0);
                @(posedge axis_aclk); #1;
                arb_enable = 1'b1;
            end
        join
        drain();

        // randomized traffic with random backpressure and enable
        drv_done = 1'b0;
        fork
            begin
                fork
                    begin repeat (20) send_pkt(0, $urandom_range(6, 1), 2); end
                    begin repeat (20) send_pkt(1, $urandom_range(6, 1), 2); end
                join
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge axis_aclk); #1;
                    m_axis_tready = ($urandom_range(3, 0) != 0);
                    arb_enable    = ($urandom_range(9, 0) != 0);
                end
            end
        join
        m_axis_tready = 1'b1;
        arb_enable    = 1'b1;
        drain();

        // asynchronous reset in the middle of a stalled packet
        m_axis_tready = 1'b0;
        drive_src(0, 1'b1, {16{32'hA5A5_0001}}, '0, 1'b0);
        repeat (3) @(posedge axis_aclk);
        #3 axis_aresetn = 1'b0;
        #1;
        check("arst_mvalid", m_axis_tvalid, 0);
        check("arst_data", {m_axis_tdata, m_axis_tuser_mty, m_axis_tlast}, 0);
        check("arst_busy", busy, 0);
        check("arst_sready", s0_axis_tready, 0);
        check("arst_cnt", {pkt_cnt_1, pkt_cnt_0}, 0);
        drive_src(0, 1'b0, '0, '0, 1'b0);
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1 axis_aresetn = 1'b1;
        fork
            send_pkt(0, 1, 0);
            send_pkt(1, 1, 0);
        join
        drain();
        check("post_rst_len", done_q.size(), 2);
        if (done_q.size() == 2) check("post_rst_first", done_q[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        fail_now("global_watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
